// File: rtl/hazard_stall_ctrl.sv
// Load-use / multi-cycle hazard controller for the ID stage of the 5-stage MIPS pipeline.
// Define HAZ_STATS_EN to add the stall_cycles and flush_count statistics outputs.
module hazard_stall_ctrl #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             stall,
    output logic             if_id_flush,
    output logic             pipe_freeze
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_count
`endif
);

    typedef enum logic {
        IDLE,
        LSTALL
    } state_t;

    state_t             state, state_nxt;
    logic   [CNT_W-1:0] cnt, cnt_nxt;
    logic               hit;

    assign hit = id_ex_mem_read && (id_ex_rt != '0) &&
                 ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        stall       = 1'b0;
        if_id_flush = 1'b0;
        pipe_freeze = 1'b0;
        if (reset) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (mem_busy) begin
            // Freeze holds state and cnt so an interrupted stall resumes its count.
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            stall       = 1'b1;
            state_nxt   = IDLE;
            cnt_nxt     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        stall       = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_nxt = LSTALL;
                            cnt_nxt   = CNT_W'(LOAD_LAT - 2);
                        end
                    end
                end
                LSTALL: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    stall       = 1'b1;
                    if (cnt == '0) state_nxt = IDLE;
                    else           cnt_nxt   = cnt - 1'b1;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef HAZ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (!mem_busy) begin
            if (stall && !branch_taken) stall_cycles <= stall_cycles + 32'd1;
            if (if_id_flush)            flush_count  <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench: vector table against a LOAD_LAT=1 instance, hand-written sequences against LOAD_LAT=3.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset, id_ex_mem_read, if_id_uses_rt, branch_taken, mem_busy;
    logic [4:0] id_ex_rt, if_id_rs, if_id_rt;
    logic       pw1, iw1, st1, fl1, fz1;
    logic       pw3, iw3, st3, fl3, fz3;
`ifdef HAZ_STATS_EN
    logic [31:0] sc1, fc1, sc3, fc3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pw1), .if_id_write(iw1), .stall(st1), .if_id_flush(fl1), .pipe_freeze(fz1)
`ifdef HAZ_STATS_EN
        , .stall_cycles(sc1), .flush_count(fc1)
`endif
    );

    hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(3), .CNT_W(4)) u3 (
        .clk(clk), .reset(reset), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pw3), .if_id_write(iw3), .stall(st3), .if_id_flush(fl3), .pipe_freeze(fz3)
`ifdef HAZ_STATS_EN
        , .stall_cycles(sc3), .flush_count(fc3)
`endif
    );

    // Expected outputs packed as {pc_write, if_id_write, stall, if_id_flush, pipe_freeze}.
    localparam logic [4:0] PASS   = 5'b11000;
    localparam logic [4:0] BUBBLE = 5'b00100;
    localparam logic [4:0] FREEZE = 5'b00001;
    localparam logic [4:0] FLUSH  = 5'b11110;

    typedef struct {
        string      name;
        logic       rst;
        logic       rd;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       br;
        logic       busy;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive inputs on the falling edge; state advances on the following rising edge.
    task automatic drive(input logic rst, input logic rd, input logic [4:0] ex_rt,
                         input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic br, input logic busy);
        @(negedge clk);
        reset          = rst;
        id_ex_mem_read = rd;
        id_ex_rt       = ex_rt;
        if_id_rs       = rs;
        if_id_rt       = rt;
        if_id_uses_rt  = uses;
        branch_taken   = br;
        mem_busy       = busy;
        #1;
    endtask

    task automatic chk3(input string name, input logic [4:0] exp);
        chk(name, {27'd0, pw3, iw3, st3, fl3, fz3}, {27'd0, exp});
    endtask

    task automatic do_reset3(input string name);
        drive(1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
        chk3(name, PASS);
    endtask

    initial begin
        reset = 1'b1; id_ex_mem_read = 1'b0; id_ex_rt = '0; if_id_rs = '0; if_id_rt = '0;
        if_id_uses_rt = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;

        vecs[0]  = '{"reset_out",      1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, PASS};
        vecs[1]  = '{"rs_hit",         0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, BUBBLE};
        vecs[2]  = '{"no_load",        0, 0, 5'd5, 5'd5, 5'd5, 1, 0, 0, PASS};
        vecs[3]  = '{"reg0_rs",        0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, PASS};
        vecs[4]  = '{"rt_unused",      0, 1, 5'd7, 5'd3, 5'd7, 0, 0, 0, PASS};
        vecs[5]  = '{"rt_hit",         0, 1, 5'd7, 5'd3, 5'd7, 1, 0, 0, BUBBLE};
        vecs[6]  = '{"busy_over_hit",  0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 1, FREEZE};
        vecs[7]  = '{"branch_hit",     0, 1, 5'd7, 5'd7, 5'd0, 0, 1, 0, FLUSH};
        vecs[8]  = '{"busy_over_br",   0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, FREEZE};
        vecs[9]  = '{"mismatch",       0, 1, 5'd5, 5'd6, 5'd4, 1, 0, 0, PASS};
        vecs[10] = '{"rs_and_rt_hit",  0, 1, 5'd8, 5'd8, 5'd8, 1, 0, 0, BUBBLE};

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rst, vecs[i].rd, vecs[i].ex_rt, vecs[i].rs, vecs[i].rt,
                  vecs[i].uses, vecs[i].br, vecs[i].busy);
            chk(vecs[i].name, {27'd0, pw1, iw1, st1, fl1, fz1}, {27'd0, vecs[i].exp});
        end

        // LOAD_LAT=3: hit on rt=9 stalls exactly three cycles (hit held, ignored in LSTALL).
        do_reset3("s3_reset");
        drive(0, 1, 5'd9, 5'd2, 5'd9, 1, 0, 0); chk3("s3_stall1", BUBBLE);
        drive(0, 1, 5'd9, 5'd2, 5'd9, 1, 0, 0); chk3("s3_stall2", BUBBLE);
        drive(0, 0, 5'd9, 5'd2, 5'd9, 1, 0, 0); chk3("s3_stall3", BUBBLE);
        drive(0, 0, 5'd9, 5'd2, 5'd9, 1, 0, 0); chk3("s3_idle", PASS);
`ifdef HAZ_STATS_EN
        chk("s3_stall_cycles", sc3, 32'd3);
`endif
        // Back-to-back hazard re-detected in IDLE.
        drive(0, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0); chk3("s3_redetect", BUBBLE);

        // Freeze on 2nd stall cycle for 2 cycles, then the remaining 2 stall cycles.
        do_reset3("s4_reset");
        drive(0, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0); chk3("s4_stall1", BUBBLE);
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1); chk3("s4_freeze1", FREEZE);
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1); chk3("s4_freeze2", FREEZE);
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0); chk3("s4_stall2", BUBBLE);
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0); chk3("s4_stall3", BUBBLE);
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0); chk3("s4_idle", PASS);

        // Branch in LSTALL flushes and abandons the stall.
        do_reset3("s5_reset");
        drive(0, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0); chk3("s5_stall1", BUBBLE);
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0); chk3("s5_flush", FLUSH);
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0); chk3("s5_idle", PASS);
`ifdef HAZ_STATS_EN
        chk("s5_flush_count", fc3, 32'd1);
`endif

        // Reset mid-LSTALL returns to IDLE.
        do_reset3("s6_reset0");
        drive(0, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0); chk3("s6_stall1", BUBBLE);
        drive(1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0); chk3("s6_reset_mid", PASS);
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0); chk3("s6_idle", PASS);
`ifdef HAZ_STATS_EN
        chk("s6_stall_cycles", sc3, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
